phase_to_amplitude_pipe: RTL and testbench

//  Pipelined DDS phase-to-amplitude stage; sits between the phase accumulator and the DAC.

---
 rtl/phase_to_amplitude_pipe.sv | 161 ++++++++++++++++
 tb/tb_phase_to_amplitude_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/phase_to_amplitude_pipe.sv
// Pipelined DDS phase-to-amplitude stage.
// Converts an accumulator phase plus a per-sample offset into a sine, square, triangle
// or sawtooth sample. The sample is scaled by a per-sample gain and presented in
// offset-binary. The block accepts one sample per clock and has a fixed latency of 3.
//
// Handshake: in_valid qualifies phase_in/phase_offset/amplitude_in/mode for one cycle.
// There is no ready. out_valid is high for exactly one cycle per accepted sample, three
// cycles after it was accepted. out holds its last value while out_valid is low.
module phase_to_amplitude_pipe #(
  parameter int PHASE_W  = 16,
  parameter int ADDR_W   = 9,
  parameter int OUT_W    = 9,
  parameter int AMP_W    = 9,
  parameter     LUT_FILE = "sine_quarter.hex"
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic [AMP_W-1:0]   amplitude_in,
  input  logic [1:0]         mode,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out
);

  localparam int Q = 2 ** (ADDR_W - 2);
  localparam int M = 2 ** (OUT_W - 1) - 1;
  localparam logic [OUT_W-1:0]  M_V   = OUT_W'(M);
  localparam logic [ADDR_W-2:0] Q_V   = (ADDR_W - 1)'(Q);
  localparam logic [OUT_W-1:0]  MID_V = {1'b1, {(OUT_W - 1){1'b0}}};

  // The sawtooth and the offset-binary conversion both rely on wave and output widths matching.
  if (OUT_W != ADDR_W) begin : g_width_check
    $error("phase_to_amplitude_pipe: OUT_W must equal ADDR_W");
  end

  // LUT_FILE names the quarter-wave image: round(M*sin(2*pi*k/2^N)), k = 0..Q.
  // The ROM is built at elaboration from that same formula, so it needs no preload.
  if ($bits(LUT_FILE) == 0) begin : g_lut_name_check
    $error("phase_to_amplitude_pipe: LUT_FILE must name the quarter-wave image");
  end

  function automatic int sine_val(input int k);
    real x, term, sum;
    x    = 3.14159265358979323846 / 2.0 * k / Q;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
      sum  = sum + term;
    end
    return $rtoi(M * sum + 0.5);
  endfunction

  logic [OUT_W-2:0] lut [0:Q];
  for (genvar gi = 0; gi <= Q; gi++) begin : g_lut
    localparam int V = sine_val(gi);
    assign lut[gi] = V[OUT_W-2:0];
  end

  // ---------------- S1: phase sum and per-sample controls ----------------
  logic [PHASE_W-1:0] phase_sum;
  logic               unused_phase;
  logic               v1;
  logic [ADDR_W-1:0]  a1;
  logic [1:0]         mode1;
  logic [AMP_W-1:0]   amp1;

  // The phase sum wraps modulo 2^PHASE_W and any carry out is dropped.
  assign phase_sum    = phase_in + phase_offset;
  assign unused_phase = ^phase_sum[PHASE_W-ADDR_W-1:0];

  // Register the wave address together with the controls that travel with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1    <= 1'b0;
      a1    <= '0;
      mode1 <= '0;
      amp1  <= '0;
    end else begin
      v1    <= in_valid;
      a1    <= phase_sum[PHASE_W-1 -: ADDR_W];
      mode1 <= mode;
      amp1  <= amplitude_in;
    end
  end

  // ---------------- S2: wave generation ----------------
  logic [1:0]              quad;
  logic [ADDR_W-3:0]       k;
  logic [ADDR_W-2:0]       idx;
  logic [OUT_W-1:0]        t_ext;
  logic [OUT_W-1:0]        tri_mag;
  logic [OUT_W-1:0]        saw;
  logic signed [OUT_W-1:0] wave;
  logic                    v2;
  logic signed [OUT_W-1:0] s2;
  logic [AMP_W-1:0]        amp2;

  assign quad = a1[ADDR_W-1 -: 2];
  assign k    = a1[ADDR_W-3:0];
  // Odd quadrants run the table backwards. When k = 0, Q-k reaches the T[Q] peak entry.
  assign idx  = quad[0] ? (Q_V - {1'b0, k}) : {1'b0, k};

  // Build the signed wave sample for the selected mode.
  always_comb begin
    wave    = '0;
    t_ext   = {1'b0, lut[idx]};
    saw     = {~a1[ADDR_W-1], a1[ADDR_W-2:0]};
    tri_mag = {1'b0, k, 1'b0};
    if (quad[0]) begin
      tri_mag = ({idx, 1'b0} > M_V) ? M_V : {idx, 1'b0};
    end
    case (mode1)
      2'd0:    wave = quad[1] ? -t_ext : t_ext;
      2'd1:    wave = a1[ADDR_W-1] ? -M_V : M_V;
      2'd2:    wave = quad[1] ? -tri_mag : tri_mag;
      2'd3:    wave = (saw == MID_V) ? -M_V : saw;
      default: wave = '0;
    endcase
  end

  // Registered ROM read plus wave select, with the gain and valid carried alongside.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2   <= 1'b0;
      s2   <= '0;
      amp2 <= '0;
    end else begin
      v2   <= v1;
      s2   <= wave;
      amp2 <= amp1;
    end
  end

  // ---------------- S3: scaling and offset-binary output ----------------
  logic signed [OUT_W+AMP_W:0] prod;
  logic signed [OUT_W+AMP_W:0] scaled;
  logic                        unused_scaled;

  // The floor shift keeps |scaled| <= M. Adding midscale therefore cannot wrap,
  // and it reduces to flipping the sign bit.
  assign prod          = s2 * $signed({1'b0, amp2});
  assign scaled        = prod >>> AMP_W;
  assign unused_scaled = ^scaled[OUT_W+AMP_W:OUT_W];

  // Update out only when a sample arrives, so that out holds its value across bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out       <= MID_V;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out <= {~scaled[OUT_W-1], scaled[OUT_W-2:0]};
      end
    end
  end

endmodule

// File: tb/tb_phase_to_amplitude_pipe.sv
// Testbench for phase_to_amplitude_pipe at its default parameters (N=9, M=255).
// The driver pushes a hand-computed expected sample for each valid input. The monitor
// pops and compares that value whenever out_valid is high. It also checks the
// valid-delay and output-hold behaviour.
module tb_phase_to_amplitude_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] phase_in;
  logic [15:0] phase_offset;
  logic [8:0]  amplitude_in;
  logic [1:0]  mode;
  logic        out_valid;
  logic [8:0]  out;

  logic [8:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [2:0]  vh;
  bit          chk_vh = 1'b0;
  logic [8:0]  last_out = 9'd256;

  phase_to_amplitude_pipe dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .phase_in     (phase_in),
    .phase_offset (phase_offset),
    .amplitude_in (amplitude_in),
    .mode         (mode),
    .out_valid    (out_valid),
    .out          (out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // in_valid history, used to check that out_valid follows three cycles later
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) vh <= 3'b000;
    else          vh <= {vh[1:0], in_valid};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] ph, input logic [15:0] off, input logic [8:0] amp,
                      input logic [1:0] md, input logic [8:0] expv);
    @(posedge clk);
    #1;
    in_valid     = 1'b1;
    phase_in     = ph;
    phase_offset = off;
    amplitude_in = amp;
    mode         = md;
    exp_q.push_back(expv);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (chk_vh) check("valid_delay3", {31'd0, out_valid}, {31'd0, vh[2]});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_sample: got out=%0d, expected no sample", out);
        end else begin
          check("sample", {23'd0, out}, {23'd0, exp_q.pop_front()});
        end
        last_out = out;
      end else begin
        check("hold", {23'd0, out}, {23'd0, last_out});
      end
    end else begin
      last_out = 9'd256;
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] mode_exp [4] = '{9'd353, 9'd510, 9'd319, 9'd32};

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    phase_in     = '0;
    phase_offset = '0;
    amplitude_in = '0;
    mode         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", {23'd0, out}, 32'd256);
    reset_n = 1'b1;
    chk_vh  = 1'b1;

    // sine, full gain
    send(16'h4000, 16'h0000, 9'd511, 2'd0, 9'd510);
    send(16'hC000, 16'h0000, 9'd511, 2'd0, 9'd1);
    send(16'h0000, 16'h0000, 9'd511, 2'd0, 9'd256);
    idle(4);
    // square, half gain
    send(16'h0000, 16'h0000, 9'd256, 2'd1, 9'd383);
    send(16'h8000, 16'h0000, 9'd256, 2'd1, 9'd128);
    idle(2);
    // phase wrap: 0xF000 + 0x2000 -> a = 32
    send(16'hF000, 16'h2000, 9'd511, 2'd0, 9'd353);
    // sine q1 k=10 reads T[118]=253; sine q2 k=32 -> -98
    send(16'h4500, 16'h0000, 9'd256, 2'd0, 9'd382);
    send(16'h9000, 16'h0000, 9'd511, 2'd0, 9'd158);
    // triangle: q0, q1 clamp, q3 clamp, q2
    send(16'h1000, 16'h0000, 9'd511, 2'd2, 9'd319);
    send(16'h4000, 16'h0000, 9'd511, 2'd2, 9'd510);
    send(16'hC000, 16'h0000, 9'd511, 2'd2, 9'd1);
    send(16'h8500, 16'h0000, 9'd256, 2'd2, 9'd246);
    // sawtooth: mid, -256 clamped, top
    send(16'h1000, 16'h0000, 9'd511, 2'd3, 9'd32);
    send(16'h0000, 16'h0000, 9'd511, 2'd3, 9'd1);
    send(16'hFF80, 16'h0000, 9'd511, 2'd3, 9'd510);
    idle(3);

    // zero gain is silence in every mode over a full phase sweep
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 32; i++) begin
        send(16'(i * 16'h0800), 16'h0123, 9'd0, 2'(m), 9'd256);
      end
    end
    idle(3);

    // mode cycling per sample with gaps
    for (int i = 0; i < 12; i++) begin
      send(16'h1000, 16'h0000, 9'd511, 2'(i % 4), mode_exp[i % 4]);
      if (i % 3 == 2) idle(1);
    end
    idle(5);

    // mid-stream reset discards in-flight samples at once
    send(16'h4000, 16'h0000, 9'd511, 2'd0, 9'd510);
    send(16'hC000, 16'h0000, 9'd511, 2'd0, 9'd1);
    send(16'h1000, 16'h0000, 9'd511, 2'd1, 9'd510);
    @(posedge clk);
    #2;
    chk_vh   = 1'b0;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_out", {23'd0, out}, 32'd256);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    chk_vh  = 1'b1;
    // first valid after release appears exactly three cycles later
    send(16'h4000, 16'h0000, 9'd511, 2'd0, 9'd510);
    @(negedge clk);
    check("latency_c0", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_c1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_c2", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_c3", {31'd0, out_valid}, 32'd1);
    idle(2);

    // bounded drain of the scoreboard
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
